// File: rtl/decoder_pkg.sv
// Shared definitions for the registered select decoder: mode encodings,
// operating states and the one-hot expansion helper.
package decoder_pkg;

    localparam int MAX_SEL_W = 6;
    localparam int MAX_LINES = 1 << MAX_SEL_W;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // Callers truncate the result to their own 2^SEL_W lines.
    function automatic logic [MAX_LINES-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        logic [MAX_LINES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Step-rate divider for the scan decoder: counts 0..DIV-1 while running and
// flags the terminal count from a flop so the step decision needs no compare.
module scan_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TC    = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == TC) ? '0 : cnt_q + 1'b1;
        end
        // tick_q mirrors "count sits at terminal"; with DIV=1 that is always true.
        tick_d = (cnt_d == TC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= (DIV == 1);
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with direct-load and auto-scan modes.
// Every output is a flop; the index, wrap flag and output vector update together.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int SCAN_DIV   = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  load,
    input  logic [SEL_W-1:0]      sel,
    output logic [(1<<SEL_W)-1:0] d,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);

    localparam int               LINES    = 1 << SEL_W;
    localparam logic [SEL_W-1:0] IDX_MAX  = '1;
    localparam logic [LINES-1:0] INACTIVE = {LINES{ACTIVE_LOW}};

    state_t           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [LINES-1:0] d_q, d_d;
    logic             wrap_q, wrap_d;

    logic             run, clr, step, entering, tick;

    scan_prescaler #(
        .DIV (SCAN_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .clr   (clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = OFF;
        if (en) begin
            case (mode)
                MODE_DIRECT: state_d = DIRECT;
                MODE_SCAN:   state_d = SCAN;
                default:     state_d = OFF;
            endcase
        end
    end

    // A load always beats a pending step, and entry into SCAN restarts the count.
    always_comb begin
        run      = (state_d == SCAN);
        entering = run && (state_q != SCAN);
        clr      = (state_d == DIRECT) || (run && (load || entering));
        step     = run && tick && !load && !entering;
    end

    always_comb begin
        idx_d = idx_q;
        if (load) begin
            idx_d = sel;
        end else if (step) begin
            idx_d = idx_q + 1'b1;
        end

        wrap_d = step && (idx_q == IDX_MAX);

        d_d = INACTIVE;
        if (state_d != OFF) begin
            d_d = LINES'(onehot(MAX_SEL_W'(idx_d))) ^ INACTIVE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            d_q    <= INACTIVE;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            d_q    <= d_d;
            wrap_q <= wrap_d;
        end
    end

    assign d    = d_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: doc/decoder_scan.md
# decoder_scan

Registered, parametrised N-to-2^N one-hot decoder with two modes: direct decode of a loaded select value, and auto-scan that steps the active output through all 2^N lines at a programmable rate. It replaces the combinational 2-to-4 decoder wherever a glitch-free registered select or a time-multiplexed strobe is needed, such as display digit drivers or bank enables. One output line is active at a time, or none when disabled.

## Interface
- SEL_W, default 2: select width; output count is 2^SEL_W. Legal range 1..6.
- SCAN_DIV, default 4: clock cycles per scan step. Legal range ≥ 1.
- ACTIVE_LOW, default 0: when 1, all d outputs are inverted (active line 0, inactive lines 1).
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  enable. When 0, all outputs are inactive and the index and prescaler hold their values.
- mode  input  1  0 = DIRECT, 1 = SCAN.
- load  input  1  single-cycle strobe that captures sel into the index.
- sel  input  SEL_W  select value, sampled only when load=1.
- d  output  2^SEL_W  decoded one-hot outputs (registered).
- idx  output  SEL_W  current index (registered).
- wrap  output  1  one-cycle pulse when a scan step wraps from 2^SEL_W-1 to 0.

## Operation
- States: OFF (en=0), DIRECT (en=1, mode=0), SCAN (en=1, mode=1). The state is derived from registered en/mode.
- **DIRECT:**
  - load=1 captures sel into the index.
  - d becomes the one-hot of the index.
  - The prescaler is held at 0.
- **SCAN:**
  - The prescaler counts 0..SCAN_DIV-1.
  - On the cycle the prescaler equals SCAN_DIV-1, it returns to 0 and the index increments modulo 2^SEL_W.
  - An increment from 2^SEL_W-1 to 0 asserts wrap for exactly one cycle.
  - With SCAN_DIV=1 the index steps every cycle.
- **load in SCAN:**
  - Captures sel into the index and clears the prescaler.
  - If load coincides with a step, load wins: there is no increment and no wrap.
- **Mode change:**
  - Entering SCAN from DIRECT or OFF clears the prescaler and keeps the index.
  - Leaving SCAN freezes the index at its current value.
- **OFF:**
  - d is all inactive and wrap=0.
  - load is still honoured: the index updates.
  - The prescaler holds.
- **Reset values:** index=0, prescaler=0, d=all inactive (0s, or 1s if ACTIVE_LOW), idx=0, wrap=0.
- **Output invariant:** d has exactly one active bit whenever en was 1 at the previous edge; otherwise it has none.

## Timing
- **Load latency:** load/sel sampled at edge k appear on idx and d at edge k (visible after edge k, one-cycle registered latency from input valid).
- **Enable/disable latency:**
  - en rising at edge k: d becomes active after edge k.
  - en falling: d becomes inactive after the same edge.
- **Scan period:** SCAN_DIV cycles per line and SCAN_DIV·2^SEL_W cycles per full sweep.
- **wrap timing:** wrap is asserted in the same cycle idx reads 0 after a wrap.
- **Asynchronous reset:** rst_n low forces the reset values immediately, independent of clk, including mid-scan. Operation resumes at the first rising clk edge after deassertion, starting with the prescaler at 0.
- **Glitch-free outputs:** all outputs come directly from flops, with no combinational path from inputs to outputs.

## Structure
- **Shared package `decoder_pkg`:**
  - Mode constants MODE_DIRECT=1'b0 and MODE_SCAN=1'b1.
  - State enum {OFF, DIRECT, SCAN}.
  - A function onehot(idx) returning the 2^SEL_W-bit vector.
- **Sub-module `scan_prescaler`:**
  - Parameter DIV.
  - Ports: clk, rst_n, run, clr, and tick out (registered terminal-count pulse).
- **Top level** holds the index register, the output register, the ACTIVE_LOW inversion, and the wrap flag.

## Test plan
All scenarios use SEL_W=2, SCAN_DIV=4, ACTIVE_LOW=0 unless stated otherwise.

1. **Reset:** rst_n=0 mid-scan with idx=2 → immediately d=4'b0000, idx=0, wrap=0, without waiting for a clk edge.
2. **DIRECT sweep:** en=1, mode=0, load sel=0,1,2,3 on successive cycles → d=0001, 0010, 0100, 1000, each one cycle after its load. No wrap.
3. **SCAN from idx=0:**
   - idx steps 0→1→2→3→0 every 4 cycles.
   - d follows as one-hot.
   - wrap=1 for exactly one cycle when idx returns to 0 (16 cycles after scan start).
4. **Load versus step collision:** in SCAN with idx=3 and the prescaler at 3, assert load with sel=1 → idx=1, wrap stays 0, and the next step occurs 4 cycles later to idx=2.
5. **Disable and resume:**
   - en=0 at idx=2 → d=0000 and idx holds at 2.
   - en=1 again → d=0100, and the next step occurs a full 4 cycles later.
6. **Parameter sweep:** SEL_W=3, SCAN_DIV=1, ACTIVE_LOW=1 → d walks a single 0 through 8 bits with a step every cycle, and wrap pulses every 8 cycles.
